// File: rtl/adc_to_float_pkg.sv
// adc_to_float_pkg: shared definitions for the ADC-to-float converter.
//   - state encoding of the conversion FSM
//   - exponent bias / start value and float constants
package adc_to_float_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS    = 3'd1,
        ST_NORM   = 3'd2,
        ST_PACK   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int          EXP_BIAS_DEF = 127;
    // Exponent of a magnitude whose MSB sits at bit 23: bias + 23.
    localparam logic [7:0]  EXP_START    = 8'd150;
    localparam logic [31:0] F_ZERO       = 32'h0000_0000;
    localparam logic [31:0] F_ONE        = 32'h3F80_0000;

endpackage

// File: rtl/adc_to_float_if.sv
// adc_to_float_if: sample-in / float-out handshake bundle.
//   i_ADC_DATA, i_ADC_DATA_VALID, o_ADC_DATA_READY : sample side
//   o_F_DATA, o_F_DATA_VALID, i_F_ACK             : float side
// slave  : the converter
// master : the producer/consumer environment around it
interface adc_to_float_if #(
    parameter int IN_WIDTH = 24
);
    logic [IN_WIDTH-1:0] i_ADC_DATA;
    logic                i_ADC_DATA_VALID;
    logic                o_ADC_DATA_READY;
    logic [31:0]         o_F_DATA;
    logic                o_F_DATA_VALID;
    logic                i_F_ACK;

    modport slave (
        input  i_ADC_DATA, i_ADC_DATA_VALID, i_F_ACK,
        output o_ADC_DATA_READY, o_F_DATA, o_F_DATA_VALID
    );

    modport master (
        output i_ADC_DATA, i_ADC_DATA_VALID, i_F_ACK,
        input  o_ADC_DATA_READY, o_F_DATA, o_F_DATA_VALID
    );
endinterface

// File: rtl/adc_to_float.sv
// adc_to_float: signed 24-bit ADC sample -> IEEE-754 single float.
// Exact conversion (24-bit magnitude fits the 24-bit significand), normalised
// one bit per cycle. Single sample in flight; result held until acknowledged.
// Ports:
//   i_CLK  : clock, rising edge
//   i_RSTN : asynchronous active-low reset
//   bus    : adc_to_float_if.slave (sample in, float out, ack)
module adc_to_float
    import adc_to_float_pkg::*;
#(
    parameter int IN_WIDTH = 24,
    parameter int EXP_BIAS = EXP_BIAS_DEF
) (
    input  logic           i_CLK,
    input  logic           i_RSTN,
    adc_to_float_if.slave  bus
);

    localparam int         MSB     = IN_WIDTH - 1;
    localparam logic [7:0] EXP_TOP = 8'(EXP_BIAS + IN_WIDTH - 1);

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] sample_q;
    logic [IN_WIDTH-1:0] mag_q;
    logic [7:0]          exp_q;
    logic                sign_q;
    logic                zero_q;
    logic [IN_WIDTH-1:0] abs_val;

    // -8388608 wraps to 0x800000, which is the correct unsigned magnitude.
    assign abs_val = sample_q[MSB] ? (~sample_q + {{(IN_WIDTH-1){1'b0}}, 1'b1})
                                   : sample_q;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.i_ADC_DATA_VALID && bus.o_ADC_DATA_READY) state_d = ST_ABS;
            ST_ABS:    state_d = (abs_val == '0) ? ST_PACK : ST_NORM;
            ST_NORM:   if (mag_q[MSB]) state_d = ST_PACK;
            ST_PACK:   state_d = ST_FINISH;
            ST_FINISH: if (bus.o_F_DATA_VALID && bus.i_F_ACK) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            sample_q             <= '0;
            mag_q                <= '0;
            exp_q                <= '0;
            sign_q               <= 1'b0;
            zero_q               <= 1'b0;
            bus.o_ADC_DATA_READY <= 1'b1;
            bus.o_F_DATA         <= F_ZERO;
            bus.o_F_DATA_VALID   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_ADC_DATA_VALID && bus.o_ADC_DATA_READY) begin
                        sample_q             <= bus.i_ADC_DATA;
                        bus.o_ADC_DATA_READY <= 1'b0;
                    end
                end
                ST_ABS: begin
                    sign_q <= sample_q[MSB];
                    mag_q  <= abs_val;
                    exp_q  <= EXP_TOP;
                    zero_q <= (abs_val == '0);
                end
                ST_NORM: begin
                    // Nonzero magnitude: loop ends within 23 shifts, exp >= bias.
                    if (!mag_q[MSB]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                ST_PACK: begin
                    // Zero packs as +0 regardless of sign/exp contents.
                    bus.o_F_DATA       <= zero_q ? F_ZERO : {sign_q, exp_q, mag_q[MSB-1:0]};
                    bus.o_F_DATA_VALID <= 1'b1;
                end
                ST_FINISH: begin
                    if (bus.o_F_DATA_VALID && bus.i_F_ACK) begin
                        bus.o_F_DATA_VALID   <= 1'b0;
                        bus.o_ADC_DATA_READY <= 1'b1;
                    end
                end
                default: begin
                    bus.o_F_DATA_VALID   <= 1'b0;
                    bus.o_ADC_DATA_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_to_float.md
# adc_to_float

Converts signed 24-bit two's-complement ADC samples into IEEE-754 single-precision floats for the floating-point filter chain. Sits directly upstream of the IIR notch stage: its output port pair matches the notch input handshake (`i_X_DATA` / `i_X_DATA_VALID` / `o_X_DATA_READY`). Conversion is exact: 24 bits of magnitude fit the 24-bit significand, so no rounding is needed. Normalisation is sequential, one bit per cycle.

## Interface
- `IN_WIDTH`, default 24: ADC sample width. Fixed at 24; other values are unsupported.
- `EXP_BIAS`, default 127: IEEE-754 exponent bias.

- `i_CLK` in 1: clock; all state changes on the rising edge.
- `i_RSTN` in 1: reset, asynchronous, active-low.
- `i_ADC_DATA` in 24: signed two's-complement sample.
- `i_ADC_DATA_VALID` in 1: sample valid.
- `o_ADC_DATA_READY` out 1: block idle and able to accept a sample.
- `o_F_DATA` out 32: float result.
- `o_F_DATA_VALID` out 1: result valid; held until acknowledged.
- `i_F_ACK` in 1: consumer has taken `o_F_DATA`.

## Operation
- Reset values:
  - `o_ADC_DATA_READY` = 1, `o_F_DATA` = 0, `o_F_DATA_VALID` = 0.
  - Internal magnitude register = 0, exponent register = 0, sign register = 0.
  - State = ST_IDLE.
- States: ST_IDLE, ST_ABS, ST_NORM, ST_PACK, ST_FINISH. Any unused encoding returns to ST_IDLE.
- ST_IDLE:
  - Drive ready = 1.
  - When `i_ADC_DATA_VALID && o_ADC_DATA_READY`: latch the sample, drive ready = 0, go to ST_ABS.
- ST_ABS:
  - sign = sample[23].
  - mag = sign ? (~sample + 1) : sample, as 24-bit unsigned. -8388608 gives 0x800000.
  - exp = 150 (bias + 23).
  - If mag == 0, set a zero flag and go to ST_PACK; otherwise go to ST_NORM.
- ST_NORM:
  - If mag[23] == 1, go to ST_PACK.
  - Otherwise mag <<= 1, exp -= 1, and stay in ST_NORM.
  - At most 23 shifts; exp never drops below 127.
- ST_PACK:
  - `o_F_DATA` = {sign, exp[7:0], mag[22:0]}.
  - With the zero flag set, output 0x00000000. Negative zero is never produced.
  - Drive `o_F_DATA_VALID` = 1 and go to ST_FINISH.
- ST_FINISH:
  - Hold `o_F_DATA` and `o_F_DATA_VALID` stable.
  - On an edge where `o_F_DATA_VALID && i_F_ACK`: drive valid = 0, ready = 1, go to ST_IDLE.
- `i_ADC_DATA_VALID` while ready = 0 is ignored. There is no buffering; upstream holds its sample or accepts the drop.
- `i_F_ACK` while valid = 0 is ignored.
- Denormals, infinities and NaN are never generated.

## Timing
- Edge E0 accepts the sample. Let k = number of leading zeros of mag (0..23).
- Nonzero sample: `o_F_DATA_VALID` rises after edge E(k+3). Latency is 3 cycles minimum (|x| ≥ 2^23) and 26 cycles maximum (|x| = 1).
- Zero sample: valid rises after edge E2.
- After ACK is sampled at edge Ea: valid falls and ready rises after Ea. The earliest next accept is edge Ea+1.
- Single-sample occupancy, no pipelining. Worst-case throughput is 1 sample per 28 cycles, far above the ADC output rate.
- ACK held high continuously: valid is high for exactly one cycle.
- `i_RSTN` low at any time, including mid-ST_NORM or mid-ST_FINISH, asynchronously forces all reset values. Any in-flight sample is discarded and no partial result is emitted.

## Structure
- Shared package:
  - 3-bit state encodings.
  - EXP_BIAS, the exponent start value 150, and the float zero constant 0x00000000.
  - The float one constant 0x3F800000, for bench use.
- No sub-module is natural. The sign/magnitude step, shift loop and packer form one FSM of about 150–200 lines.

## Test plan
- 0x000001 → 0x3F800000 after 26 cycles. 0xFFFFFF (-1) → 0xBF800000 after 26 cycles.
- 0x000000 → 0x00000000 after 2 cycles; sign bit clear.
- 0x7FFFFF → 0x4AFFFFFE after 4 cycles. 0x800000 → 0xCB000000 after 3 cycles.
- Withhold ACK for 10 cycles: output stable with valid high; a second sample with valid high during this window is not accepted and ready stays 0. ACK → valid 0 next edge, the next sample is accepted one cycle later.
- Assert reset mid-ST_NORM on sample 0x000010: all outputs return to reset values immediately. The following sample 0x000002 → 0x40000000 with no stale sign or exponent.
- Back-to-back random 24-bit samples with random ACK delays, connected to a notch stage model: every output matches a bit-exact reference conversion, and the handshakes never lose or duplicate a sample.
